// File: rtl/sram_like_bridge_pkg.sv
// Shared types and constants for the CPU SRAM port to sram-like bus bridge.
package sram_like_bridge_pkg;

  localparam int unsigned SizeW = 2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  typedef enum logic [SizeW-1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } size_e;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

endpackage

// File: rtl/sram_like_bridge_if.sv
// CPU-side SRAM port and sram-like bus signals of one bridge instance.
interface sram_like_bridge_if
  import sram_like_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  cpu_en;
  logic [DATA_W/8-1:0]   cpu_wen;
  logic [SizeW-1:0]      cpu_size;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic                  cpu_cancel;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_stall;

  logic                  bus_req;
  logic                  bus_wr;
  logic [SizeW-1:0]      bus_size;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_uncached;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_err;

  // Bridge view.
  modport slave (
    input  cpu_en, cpu_wen, cpu_size, cpu_addr, cpu_wdata, cpu_cancel,
    output cpu_rdata, cpu_stall,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_uncached, bus_err,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  // Pipeline plus downstream bus view.
  modport master (
    output cpu_en, cpu_wen, cpu_size, cpu_addr, cpu_wdata, cpu_cancel,
    input  cpu_rdata, cpu_stall,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_uncached, bus_err,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/sram_like_bridge_addr_seg_map.sv
// kseg0/kseg1 virtual-to-physical mapping with uncached flag; purely combinational.
module sram_like_bridge_addr_seg_map
  import sram_like_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          SEG_MAP_EN = 1'b1
) (
  input  logic [ADDR_W-1:0] vaddr,
  output logic [ADDR_W-1:0] paddr,
  output logic              uncached
);
  logic [2:0] top;

  assign top = vaddr[ADDR_W-1 -: 3];

  always_comb begin
    uncached = (top == KSEG1);
    paddr    = vaddr;
    if (SEG_MAP_EN && ((top == KSEG0) || (top == KSEG1))) begin
      paddr = {3'b000, vaddr[ADDR_W-4:0]};
    end
  end
endmodule

// File: rtl/sram_like_bridge.sv
// Blocking CPU SRAM port to split-transaction sram-like bus, one outstanding access.
module sram_like_bridge
  import sram_like_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter bit          SEG_MAP_EN = 1'b1,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_bridge_if.slave   br
);
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e              state_q;
  logic                bus_req_q, wr_q, uncached_q, err_q, drop_q, stray_q;
  logic [SizeW-1:0]    size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [CntW-1:0]     cnt_q;

  logic [ADDR_W-1:0]   paddr;
  logic                uncached;
  logic                drop_now, rsp;

  sram_like_bridge_addr_seg_map #(
    .ADDR_W    (ADDR_W),
    .SEG_MAP_EN(SEG_MAP_EN)
  ) u_seg_map (
    .vaddr   (br.cpu_addr),
    .paddr   (paddr),
    .uncached(uncached)
  );

  assign drop_now = drop_q | br.cpu_cancel;
  // A response owed to a timed-out access must not complete the next one.
  assign rsp      = br.bus_data_ok & ~stray_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      bus_req_q  <= 1'b0;
      wr_q       <= 1'b0;
      uncached_q <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      stray_q    <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      if (stray_q && br.bus_data_ok) stray_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (br.cpu_en) begin
            state_q    <= StReq;
            bus_req_q  <= 1'b1;
            wr_q       <= |br.cpu_wen;
            size_q     <= br.cpu_size;
            addr_q     <= paddr;
            wdata_q    <= br.cpu_wdata;
            uncached_q <= uncached;
            drop_q     <= 1'b0;
          end
        end
        StReq: begin
          if (br.cpu_cancel) drop_q <= 1'b1;
          if (br.bus_addr_ok) begin
            bus_req_q <= 1'b0;
            if (rsp) begin
              state_q <= drop_now ? StIdle : StDone;
              if (!drop_now && !wr_q) rdata_q <= br.bus_rdata;
            end else begin
              state_q <= StWait;
              cnt_q   <= '0;
              err_q   <= (TIMEOUT == 32'd1);
            end
          end
        end
        StWait: begin
          if (br.cpu_cancel) drop_q <= 1'b1;
          if (err_q) begin
            // Timeout wins over a same-cycle response.
            state_q <= drop_now ? StIdle : StDone;
            err_q   <= 1'b0;
            stray_q <= ~br.bus_data_ok;
            if (!drop_now) rdata_q <= '0;
          end else if (rsp) begin
            state_q <= drop_now ? StIdle : StDone;
            if (!drop_now && !wr_q) rdata_q <= br.bus_rdata;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            err_q <= (TIMEOUT != 0) && (cnt_q + CntW'(1) == CntW'(TIMEOUT - 1));
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

  assign br.cpu_stall    = resetn & ((state_q == StReq) || (state_q == StWait) ||
                                     ((state_q == StIdle) && br.cpu_en));
  assign br.cpu_rdata    = rdata_q;
  assign br.bus_req      = bus_req_q;
  assign br.bus_wr       = wr_q;
  assign br.bus_size     = size_q;
  assign br.bus_addr     = addr_q;
  assign br.bus_wdata    = wdata_q;
  assign br.bus_uncached = uncached_q;
  assign br.bus_err      = err_q;
endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge with hand-computed expectations, TIMEOUT=4.
module tb_sram_like_bridge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  sram_like_bridge #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .SEG_MAP_EN(1'b1),
    .TIMEOUT   (4)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .br    (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cpu_req(input logic [3:0] wen, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bif.cpu_en    = 1'b1;
    bif.cpu_wen   = wen;
    bif.cpu_size  = size;
    bif.cpu_addr  = addr;
    bif.cpu_wdata = wdata;
  endtask

  initial begin
    bif.cpu_en      = 1'b0;
    bif.cpu_wen     = '0;
    bif.cpu_size    = '0;
    bif.cpu_addr    = '0;
    bif.cpu_wdata   = '0;
    bif.cpu_cancel  = 1'b0;
    bif.bus_addr_ok = 1'b0;
    bif.bus_data_ok = 1'b0;
    bif.bus_rdata   = '0;
    #3;
    check("rst_stall", bif.cpu_stall, 0);
    check("rst_req", bif.bus_req, 0);
    check("rst_wr", bif.bus_wr, 0);
    check("rst_err", bif.bus_err, 0);
    check("rst_rdata", bif.cpu_rdata, 0);
    check("rst_addr", bif.bus_addr, 0);
    step();
    step();
    resetn = 1'b1;
    step();

    // Uncached kseg1 read, single-cycle handshake.
    cpu_req(4'b0000, 2'd2, 32'hBFC0_0000, 32'h0);
    #1 check("t1_stall_idle", bif.cpu_stall, 1);
    step();
    check("t1_req", bif.bus_req, 1);
    check("t1_addr", bif.bus_addr, 32'h1FC0_0000);
    check("t1_unc", bif.bus_uncached, 1);
    check("t1_wr", bif.bus_wr, 0);
    check("t1_stall_req", bif.cpu_stall, 1);
    bif.bus_addr_ok = 1'b1;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata   = 32'h1234_5678;
    step();
    bif.bus_addr_ok = 1'b0;
    bif.bus_data_ok = 1'b0;
    #1;
    check("t1_stall_done", bif.cpu_stall, 0);
    check("t1_rdata", bif.cpu_rdata, 32'h1234_5678);
    check("t1_req_done", bif.bus_req, 0);
    step();
    bif.cpu_en = 1'b0;

    // Cached kseg0 halfword write, addr_ok after 3 cycles, data_ok 2 later.
    step();
    cpu_req(4'b0011, 2'd1, 32'h8000_0010, 32'hAABB_CCDD);
    step();
    for (int r = 1; r <= 4; r++) begin
      check($sformatf("t2_req_c%0d", r), bif.bus_req, 1);
      if (r == 4) bif.bus_addr_ok = 1'b1;
      step();
    end
    bif.bus_addr_ok = 1'b0;
    check("t2_req_drop", bif.bus_req, 0);
    check("t2_wr", bif.bus_wr, 1);
    check("t2_addr", bif.bus_addr, 32'h0000_0010);
    check("t2_unc", bif.bus_uncached, 0);
    check("t2_wdata", bif.bus_wdata, 32'hAABB_CCDD);
    check("t2_size", bif.bus_size, 1);
    check("t2_stall_w1", bif.cpu_stall, 1);
    step();
    check("t2_stall_w2", bif.cpu_stall, 1);
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata   = 32'h5555_5555;
    step();
    bif.bus_data_ok = 1'b0;
    #1;
    check("t2_stall_done", bif.cpu_stall, 0);
    check("t2_rdata_kept", bif.cpu_rdata, 32'h1234_5678);
    step();
    bif.cpu_en = 1'b0;

    // kuseg read passes unchanged, response one cycle after addr_ok.
    step();
    cpu_req(4'b0000, 2'd2, 32'h0040_0000, 32'h0);
    step();
    check("t3_addr", bif.bus_addr, 32'h0040_0000);
    check("t3_unc", bif.bus_uncached, 0);
    bif.bus_addr_ok = 1'b1;
    step();
    bif.bus_addr_ok = 1'b0;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata   = 32'hCAFE_F00D;
    step();
    bif.bus_data_ok = 1'b0;
    #1 check("t3_rdata", bif.cpu_rdata, 32'hCAFE_F00D);
    step();
    bif.cpu_en = 1'b0;

    // Cancel in WAIT: result dropped and next access accepted without a DONE cycle.
    step();
    cpu_req(4'b0000, 2'd2, 32'h0000_1000, 32'h0);
    step();
    bif.bus_addr_ok = 1'b1;
    step();
    bif.bus_addr_ok = 1'b0;
    bif.cpu_cancel  = 1'b1;
    step();
    bif.cpu_cancel  = 1'b0;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata   = 32'hDEAD_BEEF;
    #1 check("t4_stall_w2", bif.cpu_stall, 1);
    step();
    bif.bus_data_ok = 1'b0;
    bif.cpu_addr    = 32'h0000_2000;
    #1;
    check("t4_rdata_kept", bif.cpu_rdata, 32'hCAFE_F00D);
    check("t4_no_done", bif.cpu_stall, 1);
    step();
    check("t4_next_req", bif.bus_req, 1);
    check("t4_next_addr", bif.bus_addr, 32'h0000_2000);
    bif.bus_addr_ok = 1'b1;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata   = 32'h0BAD_C0DE;
    step();
    bif.bus_addr_ok = 1'b0;
    bif.bus_data_ok = 1'b0;
    #1 check("t4_next_rdata", bif.cpu_rdata, 32'h0BAD_C0DE);
    step();
    bif.cpu_en = 1'b0;

    // Timeout: data_ok never arrives, bus_err on the 4th WAIT cycle.
    step();
    cpu_req(4'b0000, 2'd2, 32'h0000_3000, 32'h0);
    step();
    bif.bus_addr_ok = 1'b1;
    step();
    bif.bus_addr_ok = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      check($sformatf("t5_err_w%0d", w), bif.bus_err, 0);
      step();
    end
    check("t5_err_w4", bif.bus_err, 1);
    check("t5_stall_w4", bif.cpu_stall, 1);
    step();
    check("t5_err_done", bif.bus_err, 0);
    check("t5_stall_done", bif.cpu_stall, 0);
    check("t5_rdata_zero", bif.cpu_rdata, 0);
    step();
    bif.cpu_en      = 1'b0;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata   = 32'h1111_1111;
    step();
    bif.bus_data_ok = 1'b0;
    check("t5_stray_rdata", bif.cpu_rdata, 0);
    check("t5_stray_stall", bif.cpu_stall, 0);

    // Async reset while in REQ, then a fresh kseg1 read.
    step();
    cpu_req(4'b0000, 2'd2, 32'h9FC0_0100, 32'h0);
    step();
    check("t6_req", bif.bus_req, 1);
    check("t6_addr", bif.bus_addr, 32'h1FC0_0100);
    resetn = 1'b0;
    #1;
    check("t6_rst_req", bif.bus_req, 0);
    check("t6_rst_stall", bif.cpu_stall, 0);
    check("t6_rst_addr", bif.bus_addr, 0);
    bif.cpu_en = 1'b0;
    step();
    resetn = 1'b1;
    step();
    cpu_req(4'b0000, 2'd2, 32'hA000_0040, 32'h0);
    step();
    check("t6_new_addr", bif.bus_addr, 32'h0000_0040);
    check("t6_new_unc", bif.bus_uncached, 1);
    bif.bus_addr_ok = 1'b1;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata   = 32'h7654_3210;
    step();
    bif.bus_addr_ok = 1'b0;
    bif.bus_data_ok = 1'b0;
    #1;
    check("t6_new_rdata", bif.cpu_rdata, 32'h7654_3210);
    check("t6_new_stall", bif.cpu_stall, 0);
    step();
    bif.cpu_en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
